// File: rtl/mem_access_sequencer_pkg.sv
// ============================================================================
// Module   : mem_access_sequencer_pkg
// Purpose  : Shared widths, read-only sector index and state encoding for the
//            memory access sequencer and its address generator.
// Options  : SEQ_SECTOR_CROSS_EN (consumed by mem_seq_addr_gen)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_sequencer_pkg;

    localparam int DATA_W = 16;   // memory word width
    localparam int ADDR_W = 4;    // word address width per sector
    localparam int SEC_W  = 4;    // sector select width
    localparam int CNT_W  = 8;    // transfer length width

    // Sector that holds constant data; it may be read but never loaded.
    localparam logic [SEC_W-1:0] ROM_SECTOR = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    function automatic logic is_rom_sector(input logic [SEC_W-1:0] sector);
        return sector == ROM_SECTOR;
    endfunction

endpackage : mem_access_sequencer_pkg

`default_nettype wire

// File: rtl/mem_seq_addr_gen.sv
// ============================================================================
// Module   : mem_seq_addr_gen
// Purpose  : Address / sector / remaining-count generator shared by the load
//            and read paths of mem_access_sequencer.
// Options  : SEQ_SECTOR_CROSS_EN - on address wrap (max -> 0) both sector
//            registers advance, and a wrap of sector A into ROM_SECTOR is
//            flagged. Undefined: address wraps inside the start sector.
// Ports    : clock, reset_n          - clock, async active-low reset
//            init                    - latch cfg_* (start of a transfer)
//            advance                 - step one word / pair
//            cfg_sector_a/b, cfg_base, cfg_count - transfer configuration
//            sector_a/b, addr        - current access location
//            remaining               - words/pairs still to access
//            last_word               - remaining == 1
//            wrap_into_rom           - advancing now would move sector A
//                                      into ROM_SECTOR
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_seq_addr_gen
    import mem_access_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              init,
    input  logic              advance,
    input  logic [SEC_W-1:0]  cfg_sector_a,
    input  logic [SEC_W-1:0]  cfg_sector_b,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic [SEC_W-1:0]  sector_a,
    output logic [SEC_W-1:0]  sector_b,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  remaining,
    output logic              last_word,
    output logic              wrap_into_rom
);

    logic [SEC_W-1:0]  sector_a_q,  sector_a_d;
    logic [SEC_W-1:0]  sector_b_q,  sector_b_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;

`ifdef SEQ_SECTOR_CROSS_EN
    logic              w_at_wrap;
    logic [SEC_W-1:0]  w_next_sector_a;
    logic [SEC_W-1:0]  w_next_sector_b;

    assign w_at_wrap       = (addr_q == {ADDR_W{1'b1}});
    assign w_next_sector_a = sector_a_q + 1'b1;
    assign w_next_sector_b = sector_b_q + 1'b1;
    assign wrap_into_rom   = w_at_wrap && is_rom_sector(w_next_sector_a);
`else
    assign wrap_into_rom   = 1'b0;
`endif

    always_comb begin
        sector_a_d  = sector_a_q;
        sector_b_d  = sector_b_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (init) begin
            sector_a_d  = cfg_sector_a;
            sector_b_d  = cfg_sector_b;
            addr_d      = cfg_base;
            remaining_d = cfg_count;
        end else if (advance) begin
            // Address rolls over naturally at the top of the sector.
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
`ifdef SEQ_SECTOR_CROSS_EN
            if (w_at_wrap) begin
                sector_a_d = w_next_sector_a;
                sector_b_d = w_next_sector_b;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sector_a_q  <= '0;
            sector_b_q  <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            sector_a_q  <= sector_a_d;
            sector_b_q  <= sector_b_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign sector_a  = sector_a_q;
    assign sector_b  = sector_b_q;
    assign addr      = addr_q;
    assign remaining = remaining_q;
    assign last_word = (remaining_q == CNT_W'(1));

endmodule : mem_seq_addr_gen

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module   : mem_access_sequencer
// Purpose  : Drives the sectored memory: bulk-loads a valid/ready word stream
//            through the write port, and streams operand pairs (sector A on
//            read port 1, sector B on read port 2, shared address) through a
//            registered valid/ready output.
// Options  : SEQ_SECTOR_CROSS_EN - transfers continue into the next sector on
//            address wrap; a load that would enter ROM_SECTOR aborts with err.
// Ports    : clock, reset_n                  - clock, async active-low reset
//            start_load, start_read          - transfer start pulses
//            cfg_sector_a/b, cfg_base, cfg_count - transfer configuration
//            in_data/in_valid/in_ready       - load stream
//            data_write, sector_write_select, write_address, en_write
//                                            - memory write port
//            read_add_1/2, read_sector_selector_1/2, read_data_1/2
//                                            - memory read ports
//            out_a/out_b/out_valid/out_ready - operand pair stream
//            busy, done, err                 - status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_load,
    input  logic              start_read,
    input  logic [SEC_W-1:0]  cfg_sector_a,
    input  logic [SEC_W-1:0]  cfg_sector_b,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_write,
    output logic [SEC_W-1:0]  sector_write_select,
    output logic [ADDR_W-1:0] write_address,
    output logic              en_write,
    output logic [ADDR_W-1:0] read_add_1,
    output logic [ADDR_W-1:0] read_add_2,
    output logic [SEC_W-1:0]  read_sector_selector_1,
    output logic [SEC_W-1:0]  read_sector_selector_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_t        state_q,     state_d;
    logic [DATA_W-1:0] out_a_q,     out_a_d;
    logic [DATA_W-1:0] out_b_q,     out_b_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q,       err_d;

    logic              w_ag_init;
    logic              w_ag_advance;
    logic [SEC_W-1:0]  w_ag_sector_a;
    logic [SEC_W-1:0]  w_ag_sector_b;
    logic [ADDR_W-1:0] w_ag_addr;
    logic [CNT_W-1:0]  w_ag_remaining;
    logic              w_ag_last;
    logic              w_ag_wrap_into_rom;

    logic              w_loading;
    logic              w_write;
    logic              w_out_free;

    mem_seq_addr_gen u_addr_gen (
        .clock         (clock),
        .reset_n       (reset_n),
        .init          (w_ag_init),
        .advance       (w_ag_advance),
        .cfg_sector_a  (cfg_sector_a),
        .cfg_sector_b  (cfg_sector_b),
        .cfg_base      (cfg_base),
        .cfg_count     (cfg_count),
        .sector_a      (w_ag_sector_a),
        .sector_b      (w_ag_sector_b),
        .addr          (w_ag_addr),
        .remaining     (w_ag_remaining),
        .last_word     (w_ag_last),
        .wrap_into_rom (w_ag_wrap_into_rom)
    );

    // Decoded straight from the state flop so that an asynchronous reset
    // drops in_ready and en_write immediately.
    assign w_loading  = (state_q == ST_LOAD);
    assign w_write    = w_loading && in_valid;
    // Output slot can take a new pair when empty or being consumed now.
    assign w_out_free = !out_valid_q || out_ready;

    always_comb begin
        state_d      = state_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_valid_d  = out_valid_q;
        err_d        = err_q;
        w_ag_init    = 1'b0;
        w_ag_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (start_load) begin
                    w_ag_init = 1'b1;
                    if (is_rom_sector(cfg_sector_a)) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else if (cfg_count == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (start_read) begin
                    w_ag_init = 1'b1;
                    state_d   = (cfg_count == '0) ? ST_FIN : ST_READ;
                end
            end

            ST_LOAD: begin
                if (w_write) begin
                    w_ag_advance = 1'b1;
                    if (w_ag_last) begin
                        state_d = ST_FIN;
                    end else if (w_ag_wrap_into_rom) begin
                        // Current word still lands; no further word is taken.
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_READ: begin
                if (w_out_free) begin
                    if (w_ag_remaining != '0) begin
                        out_a_d      = read_data_1;
                        out_b_d      = read_data_2;
                        out_valid_d  = 1'b1;
                        w_ag_advance = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready               = w_loading;
    assign en_write               = w_write;
    assign data_write             = w_loading ? in_data : '0;
    assign sector_write_select    = w_ag_sector_a;
    assign write_address          = w_ag_addr;
    assign read_add_1             = w_ag_addr;
    assign read_add_2             = w_ag_addr;
    assign read_sector_selector_1 = w_ag_sector_a;
    assign read_sector_selector_2 = w_ag_sector_b;
    assign out_a                  = out_a_q;
    assign out_b                  = out_b_q;
    assign out_valid              = out_valid_q;
    assign busy                   = (state_q != ST_IDLE);
    assign done                   = (state_q == ST_FIN);
    assign err                    = err_q;

endmodule : mem_access_sequencer

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module   : tb_mem_access_sequencer
// Purpose  : Directed self-checking bench for mem_access_sequencer. Memory
//            read ports are modelled as a fixed function of sector/address.
// Options  : SEQ_SECTOR_CROSS_EN selects the matching expected values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_load, start_read;
    logic [3:0]  cfg_sector_a, cfg_sector_b, cfg_base;
    logic [7:0]  cfg_count;
    logic [15:0] in_data;
    logic        in_valid, in_ready;
    logic [15:0] data_write;
    logic [3:0]  sector_write_select, write_address;
    logic        en_write;
    logic [3:0]  read_add_1, read_add_2, read_sector_selector_1, read_sector_selector_2;
    logic [15:0] read_data_1, read_data_2;
    logic [15:0] out_a, out_b;
    logic        out_valid, out_ready;
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_access_sequencer dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .start_load             (start_load),
        .start_read             (start_read),
        .cfg_sector_a           (cfg_sector_a),
        .cfg_sector_b           (cfg_sector_b),
        .cfg_base               (cfg_base),
        .cfg_count              (cfg_count),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .data_write             (data_write),
        .sector_write_select    (sector_write_select),
        .write_address          (write_address),
        .en_write               (en_write),
        .read_add_1             (read_add_1),
        .read_add_2             (read_add_2),
        .read_sector_selector_1 (read_sector_selector_1),
        .read_sector_selector_2 (read_sector_selector_2),
        .read_data_1            (read_data_1),
        .read_data_2            (read_data_2),
        .out_a                  (out_a),
        .out_b                  (out_b),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .busy                   (busy),
        .done                   (done),
        .err                    (err)
    );

    // Memory contents: each word encodes its own location.
    function automatic logic [15:0] mem_word(input logic [3:0] s, input logic [3:0] a);
        return {s, a, ~s, ~a};
    endfunction

    assign read_data_1 = mem_word(read_sector_selector_1, read_add_1);
    assign read_data_2 = mem_word(read_sector_selector_2, read_add_2);

    function automatic logic [63:0] wr_vec();
        return {39'd0, en_write, sector_write_select, write_address, data_write};
    endfunction

    function automatic logic [63:0] status_vec();
        return {58'd0, en_write, in_ready, out_valid, busy, done, err};
    endfunction

    function automatic logic [63:0] exp_wr(input logic [3:0] s, input logic [3:0] a,
                                           input logic [15:0] d);
        return {39'd0, 1'b1, s, a, d};
    endfunction

    function automatic logic [63:0] exp_status(input logic [5:0] st);
        return {58'd0, st};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected write locations for the cross-sector load.
    logic [3:0]  exp_sec  [4];
    logic [3:0]  exp_addr [4];
    // Backpressured read: ready pattern, pair index held (-1 = none) and
    // read address per cycle after the start.
    logic        rdy_tab  [9];
    int          idx_tab  [9];
    logic [3:0]  radd_tab [9];
    logic [15:0] exp_d;

    initial begin
        reset_n      = 1'b0;
        start_load   = 1'b0;
        start_read   = 1'b0;
        cfg_sector_a = '0;
        cfg_sector_b = '0;
        cfg_base     = '0;
        cfg_count    = '0;
        in_data      = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;

`ifdef SEQ_SECTOR_CROSS_EN
        exp_sec  = '{4'd2, 4'd2, 4'd3, 4'd3};
`else
        exp_sec  = '{4'd2, 4'd2, 4'd2, 4'd2};
`endif
        exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
        rdy_tab  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        idx_tab  = '{-1, 0, 0, 0, 1, 2, 2, 2, 3};
        radd_tab = '{4'd6, 4'd7, 4'd7, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd10};

        // ---------------- reset state ----------------
        @(negedge clock);
        @(negedge clock);
        check("reset_status", status_vec(), exp_status(6'b000000));
        check("reset_write_port", wr_vec(), 64'd0);
        check("reset_read_port", {48'd0, read_add_1, read_add_2,
              read_sector_selector_1, read_sector_selector_2}, 64'd0);
        check("reset_out_data", {32'd0, out_a, out_b}, 64'd0);
        reset_n = 1'b1;

        // ---------------- load sector 2, base 14, count 4 ----------------
        @(negedge clock);
        cfg_sector_a = 4'd2; cfg_base = 4'd14; cfg_count = 8'd4;
        start_load = 1'b1; in_valid = 1'b1; in_data = 16'hA000;
        exp_d = 16'hA000;
        @(negedge clock);
        start_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("load_wrap_write", wr_vec(), exp_wr(exp_sec[k], exp_addr[k], exp_d));
            exp_d   = exp_d + 16'd1;
            in_data = exp_d;
            @(negedge clock);
        end
        check("load_wrap_done", status_vec(), exp_status(6'b000110));
        @(negedge clock);
        check("load_wrap_idle", status_vec(), exp_status(6'b000000));
        in_valid = 1'b0;

        // ---------------- load sector 14, base 15, count 3 ----------------
        @(negedge clock);
        cfg_sector_a = 4'd14; cfg_base = 4'd15; cfg_count = 8'd3;
        start_load = 1'b1; in_valid = 1'b1; in_data = 16'hB000;
        @(negedge clock);
        start_load = 1'b0;
        check("rom_guard_first_write", wr_vec(), exp_wr(4'd14, 4'd15, 16'hB000));
        in_data = 16'hB001;
        @(negedge clock);
`ifdef SEQ_SECTOR_CROSS_EN
        check("rom_guard_abort", status_vec(), exp_status(6'b000111));
`else
        check("nocross_write1", wr_vec(), exp_wr(4'd14, 4'd0, 16'hB001));
        in_data = 16'hB002;
        @(negedge clock);
        check("nocross_write2", wr_vec(), exp_wr(4'd14, 4'd1, 16'hB002));
        @(negedge clock);
        check("nocross_done", status_vec(), exp_status(6'b000110));
`endif
        @(negedge clock);
        check("rom_guard_idle", status_vec(), exp_status(6'b000000));
        in_valid = 1'b0;

        // ---------------- direct load into ROM sector ----------------
        cfg_sector_a = 4'd15; cfg_base = 4'd0; cfg_count = 8'd2;
        start_load = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        start_load = 1'b0;
        check("rom_load_err", status_vec(), exp_status(6'b000111));
        @(negedge clock);
        check("rom_load_idle", status_vec(), exp_status(6'b000000));
        in_valid = 1'b0;

        // ---------------- read A=1, B=15, base 0, count 16 ----------------
        cfg_sector_a = 4'd1; cfg_sector_b = 4'd15; cfg_base = 4'd0; cfg_count = 8'd16;
        start_read = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        start_read = 1'b0;
        check("read_first_cycle", status_vec(), exp_status(6'b000100));
        check("read_ports", {48'd0, read_add_1, read_add_2,
              read_sector_selector_1, read_sector_selector_2},
              {48'd0, 4'd0, 4'd0, 4'd1, 4'd15});
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            check("read_stream_pair", {31'd0, out_valid, out_a, out_b},
                  {31'd0, 1'b1, mem_word(4'd1, 4'(k)), mem_word(4'd15, 4'(k))});
        end
        @(negedge clock);
        check("read_stream_done", status_vec(), exp_status(6'b000110));
        @(negedge clock);
        check("read_stream_idle", status_vec(), exp_status(6'b000000));

        // ---------------- read A=3, B=4, base 6, count 4, backpressure -----
        cfg_sector_a = 4'd3; cfg_sector_b = 4'd4; cfg_base = 4'd6; cfg_count = 8'd4;
        start_read = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            start_read = 1'b0;
            out_ready  = rdy_tab[k];
            check("bp_valid_addr", {59'd0, out_valid, read_add_2},
                  {59'd0, (idx_tab[k] >= 0), radd_tab[k]});
            if (idx_tab[k] >= 0) begin
                check("bp_pair", {32'd0, out_a, out_b},
                      {32'd0, mem_word(4'd3, 4'(4'd6 + 4'(idx_tab[k]))),
                       mem_word(4'd4, 4'(4'd6 + 4'(idx_tab[k])))});
            end
        end
        @(negedge clock);
        check("bp_done", status_vec(), exp_status(6'b000110));
        @(negedge clock);
        check("bp_idle", status_vec(), exp_status(6'b000000));

        // ---------------- simultaneous starts, start while busy -----------
        cfg_sector_a = 4'd5; cfg_sector_b = 4'd6; cfg_base = 4'd0; cfg_count = 8'd2;
        start_load = 1'b1; start_read = 1'b1; in_valid = 1'b1; in_data = 16'hC000;
        @(negedge clock);
        start_load = 1'b0;
        check("both_start_load_wins", status_vec(), exp_status(6'b110100));
        check("both_start_write0", wr_vec(), exp_wr(4'd5, 4'd0, 16'hC000));
        in_data = 16'hC001;
        @(negedge clock);
        start_read = 1'b0;
        check("both_start_write1", wr_vec(), exp_wr(4'd5, 4'd1, 16'hC001));
        @(negedge clock);
        check("both_start_done", status_vec(), exp_status(6'b000110));
        @(negedge clock);
        check("busy_start_ignored", status_vec(), exp_status(6'b000000));

        // ---------------- empty load ----------------
        cfg_count = 8'd0; start_load = 1'b1;
        @(negedge clock);
        start_load = 1'b0;
        check("empty_load_done", status_vec(), exp_status(6'b000110));
        @(negedge clock);
        check("empty_load_idle", status_vec(), exp_status(6'b000000));
        in_valid = 1'b0;

        // ---------------- reset mid-load ----------------
        cfg_sector_a = 4'd4; cfg_base = 4'd0; cfg_count = 8'd8;
        start_load = 1'b1; in_valid = 1'b1; in_data = 16'hD000;
        @(negedge clock);
        start_load = 1'b0;
        check("mid_reset_pre_write", wr_vec(), exp_wr(4'd4, 4'd0, 16'hD000));
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_async_status", status_vec(), exp_status(6'b000000));
        check("mid_reset_async_write", wr_vec(), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        cfg_sector_a = 4'd6; cfg_base = 4'd3; cfg_count = 8'd1;
        start_load = 1'b1; in_data = 16'hE000;
        @(negedge clock);
        start_load = 1'b0;
        check("post_reset_status", status_vec(), exp_status(6'b110100));
        check("post_reset_write", wr_vec(), exp_wr(4'd6, 4'd3, 16'hE000));
        @(negedge clock);
        check("post_reset_done", status_vec(), exp_status(6'b000110));
        in_valid = 1'b0;
        @(negedge clock);
        check("post_reset_idle", status_vec(), exp_status(6'b000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_access_sequencer

`default_nettype wire

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Initiator that drives the sectored weight/activation memory's write port and its two read ports.
- Bulk-loads a valid/ready word stream into consecutive sector/address locations.
- Streams out operand pairs: sector A on read port 1 and sector B on read port 2, at a shared address, through a registered valid/ready output.
- Sits between the autoencoder datapath/host loader and the memory top level.

Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 4, word address width per sector (16 words/sector)
- SEC_W, 4, sector select width (16 sectors)
- CNT_W, 8, transfer length width
- ROM_SECTOR, 15, read-only sector index

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start_load  in  1  pulse: begin load transfer
- start_read  in  1  pulse: begin read transfer
- cfg_sector_a  in  SEC_W  load sector / read port-1 sector
- cfg_sector_b  in  SEC_W  read port-2 sector (ignored for load)
- cfg_base  in  ADDR_W  starting word address
- cfg_count  in  CNT_W  words (load) or pairs (read); 0 = empty transfer
- in_data  in  DATA_W  load stream data
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- data_write  out  DATA_W  to memory write data
- sector_write_select  out  SEC_W  to memory write sector
- write_address  out  ADDR_W  to memory write address
- en_write  out  1  to memory write enable
- read_add_1, read_add_2  out  ADDR_W  to memory read addresses (always equal)
- read_sector_selector_1, read_sector_selector_2  out  SEC_W  to memory read sectors
- read_data_1, read_data_2  in  DATA_W  from memory; combinational on address
- out_a, out_b  out  DATA_W  registered operand pair
- out_valid  out  1  pair valid
- out_ready  in  1  consumer ready
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  one-cycle pulse with done on protection abort

Behaviour:
- Reset (async, reset_n low):
  - state IDLE.
  - All outputs 0: en_write, in_ready, out_valid, busy, done, err, out_a/out_b, addresses, sectors, data_write.
  - Reset mid-transfer aborts immediately; en_write falls asynchronously.
- States: IDLE, LOAD, READ, FIN.
- IDLE:
  - On start_load: latch sector, base address, count; go to LOAD. start_load wins if both starts are high.
  - Otherwise on start_read: latch the same plus cfg_sector_b; go to READ.
  - With cfg_count=0, go straight to FIN; no accesses.
  - If start_load targets ROM_SECTOR, go to FIN with err.
  - Starts are ignored whenever state is not IDLE.
- LOAD:
  - in_ready=1.
  - en_write = in_valid & in_ready (combinational); data_write = in_data; sector_write_select/write_address come from registers.
  - Each accepted word: address+1, remaining-1. The final word moves to FIN.
  - Load latency: zero cycles from handshake to the memory write edge.
- READ:
  - Read addresses and sectors are driven from registers.
  - Capture condition: remaining>0 and (!out_valid | out_ready).
  - On capture: out_a<=read_data_1, out_b<=read_data_2, out_valid<=1, address+1, remaining-1.
  - Otherwise hold address, out_valid and out data; output is stable under backpressure.
  - When remaining==0 and (!out_valid | out_ready): clear out_valid, go to FIN.
  - Full throughput: one pair per cycle with out_ready held high. First out_valid appears 2 cycles after the start pulse.
  - Reading ROM_SECTOR is legal on either port.
- Address wrap, write_address 15→0 (all sectors involved advance together, read sectors A and B or load sector):
  - With SEQ_SECTOR_CROSS_EN: sector+1. A load advancing into ROM_SECTOR aborts via FIN with err; the in-flight word is already written, the next is not accepted.
  - Without SEQ_SECTOR_CROSS_EN: address wraps within the same sector.
- FIN: done=1 for one cycle (err alongside if aborted), in_ready=0, go to IDLE.
- busy=1 in LOAD, READ and FIN.

Optional Feature:
- Macro: SEQ_SECTOR_CROSS_EN.
- Defined: transfers span sectors on address wrap; load is guarded against entering ROM_SECTOR; max transfer is 2^CNT_W-1 words.
- Undefined: address wraps modulo 16 within the start sector, sector registers stay constant, and no wrap-induced err exists.

Decomposition:
- Shared package: DATA_W/ADDR_W/SEC_W/CNT_W, ROM_SECTOR constant, state encoding (IDLE=0, LOAD=1, READ=2, FIN=3).
- Sub-module mem_seq_addr_gen: holds the address/sector/remaining counters and applies wrap, cross and ROM-guard logic. It is shared by the load and read paths.

Test Plan:
- Load sector 2, base 14, count 4, in_valid always high, SEQ_SECTOR_CROSS_EN defined → writes at (2,14),(2,15),(3,0),(3,1) on consecutive edges; done on cycle 5; err=0.
- Load sector 14, base 15, count 3, crossing enabled → one write to (14,15); then done+err, in_ready=0, no write to sector 15.
- Read A=1, B=15, base 0, count 16, out_ready=1 → 16 consecutive pairs equal memory[1][i], rom[i]; done after the last handshake.
- Read count 4 with out_ready toggled 1,0,0,1,… → no pair lost or duplicated; out_a/out_b and read addresses are stable while stalled.
- start_load and start_read in the same cycle, then start_read while busy → load executes, both extra starts ignored; cfg_count=0 → done pulse, no en_write.
- reset_n asserted mid-LOAD → en_write, in_ready, busy go to 0 asynchronously; after release a new load starts cleanly from IDLE.
